fir_coeff_pair_loader: RTL and testbench

- Sits in the user_clk domain directly downstream of the software-written FIR coefficient register for taps b16/b17, and consumes its 32-bit user_data_out word.
- Qualifies a new word as stable, holds it pending, and applies it to the FIR datapath only on a frame-sync pulse. Tap coefficients therefore never change mid-frame and never take a transient value from the register's clock-domain crossing.
- Outputs the two signed 16-bit taps plus update status.

---
 rtl/fir_coeff_pkg.sv | 19 +
 rtl/fir_coeff_pair_loader_word_stability_qualifier.sv | 63 ++++++
 rtl/fir_coeff_pair_loader.sv | 112 +++++++++++
 tb/tb_fir_coeff_pair_loader.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/fir_coeff_pkg.sv
// Shared constants, register-word field layout and loader FSM states for the
// b16/b17 FIR coefficient pair loader.
package fir_coeff_pkg;

  localparam int COEF_W = 16;
  localparam int WORD_W = 2 * COEF_W;

  localparam int HI_MSB = 31;
  localparam int HI_LSB = 16;
  localparam int LO_MSB = 15;
  localparam int LO_LSB = 0;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUALIFY = 2'd1,
    PENDING = 2'd2
  } state_e;

endpackage

// File: rtl/fir_coeff_pair_loader_word_stability_qualifier.sv
// Registers the incoming coefficient word and tracks how long the latest
// candidate has been seen unchanged, flagging stable, changed and reverted.
module word_stability_qualifier
  import fir_coeff_pkg::*;
#(
  parameter int                STABLE_CYCLES = 4,
  parameter logic [WORD_W-1:0] RESET_WORD    = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [WORD_W-1:0] reg_data,
  input  logic [WORD_W-1:0] active,
  input  logic              tracking,
  output logic [WORD_W-1:0] cand,
  output logic              stable,
  output logic              changed,
  output logic              reverted
);

  localparam int              CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES);

  logic [WORD_W-1:0] regw_q, regw_d;
  logic [WORD_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              cnt_full;
  logic              load;

  always_ff @(posedge clk) begin
    if (rst) begin
      regw_q <= RESET_WORD;
      cnt_q  <= '0;
    end else begin
      regw_q <= regw_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    cand_q <= cand_d;
  end

  // A fresh candidate is captured when leaving IDLE or when the word moves
  // again while qualifying/pending; a revert to the applied word holds all.
  always_comb begin
    regw_d   = reg_data;
    reverted = (regw_q == active);
    changed  = (regw_q != cand_q);
    cnt_full = (cnt_q == CNT_MAX);
    stable   = tracking && !reverted && !changed && cnt_full;
    load     = !reverted && (!tracking || changed);
    cand_d   = load ? regw_q : cand_q;
    cnt_d    = cnt_q;
    if (load) begin
      cnt_d = CNT_W'(1);
    end else if (tracking && !reverted && !cnt_full) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  assign cand = cand_q;

endmodule

// File: rtl/fir_coeff_pair_loader.sv
// Applies a qualified b16/b17 coefficient word to the FIR taps only on a
// frame-sync pulse, reporting pending state, update pulse and update count.
module fir_coeff_pair_loader
  import fir_coeff_pkg::*;
#(
  parameter int                STABLE_CYCLES = 4,
  parameter int                COEF_W        = 16,
  parameter logic [COEF_W-1:0] RESET_COEF_HI = 16'h0000,
  parameter logic [COEF_W-1:0] RESET_COEF_LO = 16'h0000,
  parameter int                COUNT_W       = 16
) (
  input  logic                user_clk,
  input  logic                user_rst,
  input  logic [2*COEF_W-1:0] reg_data,
  input  logic                sync_in,
  output logic [COEF_W-1:0]   coef_b16,
  output logic [COEF_W-1:0]   coef_b17,
  output logic                coef_update,
  output logic                pending,
  output logic [COUNT_W-1:0]  update_count
);

  state_e               state_q, state_d;
  logic [COEF_W-1:0]    coef_hi_q, coef_hi_d;
  logic [COEF_W-1:0]    coef_lo_q, coef_lo_d;
  logic                 update_q, update_d;
  logic [COUNT_W-1:0]   count_q, count_d;

  logic [2*COEF_W-1:0]  active;
  logic [2*COEF_W-1:0]  cand;
  logic                 stable;
  logic                 changed;
  logic                 reverted;
  logic                 tracking;
  logic                 apply;

  // The applied word is exactly the concatenated tap registers.
  assign active   = {coef_hi_q, coef_lo_q};
  assign tracking = (state_q != IDLE);

  word_stability_qualifier #(
    .STABLE_CYCLES(STABLE_CYCLES),
    .RESET_WORD   ({RESET_COEF_HI, RESET_COEF_LO})
  ) u_qual (
    .clk     (user_clk),
    .rst     (user_rst),
    .reg_data(reg_data),
    .active  (active),
    .tracking(tracking),
    .cand    (cand),
    .stable  (stable),
    .changed (changed),
    .reverted(reverted)
  );

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (!reverted) state_d = QUALIFY;
      end
      QUALIFY: begin
        if (reverted)    state_d = IDLE;
        else if (stable) state_d = PENDING;
      end
      PENDING: begin
        if (reverted)     state_d = IDLE;
        else if (changed) state_d = QUALIFY;
        else if (sync_in) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A word move in the same cycle as sync_in suppresses the apply.
  always_comb begin
    pending   = (state_q == PENDING);
    apply     = (state_q == PENDING) && stable && sync_in;
    coef_hi_d = apply ? cand[HI_MSB:HI_LSB] : coef_hi_q;
    coef_lo_d = apply ? cand[LO_MSB:LO_LSB] : coef_lo_q;
    update_d  = apply;
    count_d   = apply ? count_q + COUNT_W'(1) : count_q;
  end

  always_ff @(posedge user_clk) begin
    if (user_rst) begin
      coef_hi_q <= RESET_COEF_HI;
      coef_lo_q <= RESET_COEF_LO;
      update_q  <= 1'b0;
      count_q   <= '0;
    end else begin
      coef_hi_q <= coef_hi_d;
      coef_lo_q <= coef_lo_d;
      update_q  <= update_d;
      count_q   <= count_d;
    end
  end

  assign coef_b16     = coef_hi_q;
  assign coef_b17     = coef_lo_q;
  assign coef_update  = update_q;
  assign update_count = count_q;

endmodule

// File: tb/tb_fir_coeff_pair_loader.sv
// Bench for fir_coeff_pair_loader: directed scenarios plus random traffic,
// each cycle compared against a run-length reference model.
module tb_fir_coeff_pair_loader;

  localparam int STABLE  = 4;
  localparam int CNT_W   = 10;
  localparam int CNT_MOD = 1 << CNT_W;
  localparam logic [31:0] RST_WORD = 32'h0000_0000;

  logic        user_clk = 1'b0;
  logic        user_rst = 1'b1;
  logic [31:0] reg_data = 32'h0;
  logic        sync_in  = 1'b0;
  logic [15:0] coef_b16;
  logic [15:0] coef_b17;
  logic        coef_update;
  logic        pending;
  logic [CNT_W-1:0] update_count;

  int tests = 0;
  int fails = 0;

  // Model: a word is pending once it has been the sampled value for at least
  // STABLE+1 consecutive edges and differs from the applied word.
  logic [31:0] m_regq   = RST_WORD;
  logic [31:0] m_active = RST_WORD;
  logic [31:0] m_runv   = RST_WORD;
  int          m_run    = 0;
  logic        m_pend   = 1'b0;
  logic        m_upd    = 1'b0;
  int          m_cnt    = 0;

  fir_coeff_pair_loader #(
    .STABLE_CYCLES(STABLE),
    .COEF_W       (16),
    .RESET_COEF_HI(RST_WORD[31:16]),
    .RESET_COEF_LO(RST_WORD[15:0]),
    .COUNT_W      (CNT_W)
  ) dut (
    .user_clk    (user_clk),
    .user_rst    (user_rst),
    .reg_data    (reg_data),
    .sync_in     (sync_in),
    .coef_b16    (coef_b16),
    .coef_b17    (coef_b17),
    .coef_update (coef_update),
    .pending     (pending),
    .update_count(update_count)
  );

  always #5 user_clk = ~user_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic [31:0] d, input logic s, input logic r);
    logic [31:0] sv;
    logic        same;
    logic        app;
    if (r) begin
      m_regq = RST_WORD; m_active = RST_WORD; m_runv = RST_WORD;
      m_run = 0; m_pend = 1'b0; m_upd = 1'b0; m_cnt = 0;
    end else begin
      sv   = m_regq;
      same = (sv == m_runv);
      app  = m_pend && s && same;
      if (same) begin
        if (m_run < 1000) m_run++;
      end else begin
        m_runv = sv;
        m_run  = 1;
      end
      m_upd = app;
      if (app) begin
        m_active = sv;
        m_cnt    = (m_cnt + 1) % CNT_MOD;
      end
      m_pend = !app && (sv != m_active) && (m_run >= STABLE + 1);
      m_regq = d;
    end
  endtask

  task automatic tick(input logic [31:0] d, input logic s, input logic r);
    reg_data = d;
    sync_in  = s;
    user_rst = r;
    @(posedge user_clk);
    model_edge(d, s, r);
    #1;
    check("coef_b16", {16'h0, coef_b16}, {16'h0, m_active[31:16]});
    check("coef_b17", {16'h0, coef_b17}, {16'h0, m_active[15:0]});
    check("coef_update", {31'h0, coef_update}, {31'h0, m_upd});
    check("pending", {31'h0, pending}, {31'h0, m_pend});
    check("update_count", 32'(update_count), 32'(m_cnt));
  endtask

  initial begin
    logic [31:0] pool [4];
    logic [31:0] w;
    logic        s;
    logic        r;

    // Reset, then quiet input for 100 cycles.
    tick(32'h0, 1'b0, 1'b1);
    tick(32'h0, 1'b0, 1'b1);
    check("rst_b16", {16'h0, coef_b16}, 32'h0);
    check("rst_pending", {31'h0, pending}, 32'h0);
    for (int i = 0; i < 100; i++) begin
      tick(32'h0, (i % 7) == 3, 1'b0);
      check("quiet_update", {31'h0, coef_update}, 32'h0);
    end

    // Held word, sync at edge 20.
    for (int i = 0; i <= 21; i++) begin
      tick(32'h1234_FFFE, i == 20, 1'b0);
      if (i == 4) check("hold_pend_e4", {31'h0, pending}, 32'h0);
      if (i == 5) check("hold_pend_e5", {31'h0, pending}, 32'h1);
      if (i == 20) begin
        check("hold_b16", {16'h0, coef_b16}, 32'h0000_1234);
        check("hold_b17", {16'h0, coef_b17}, 32'h0000_FFFE);
        check("hold_upd", {31'h0, coef_update}, 32'h1);
        check("hold_cnt", 32'(update_count), 32'd1);
      end
      if (i == 21) check("hold_upd_once", {31'h0, coef_update}, 32'h0);
    end

    // Word toggling faster than it can qualify.
    for (int i = 0; i < 48; i++) begin
      tick(((i / 3) % 2) != 0 ? 32'hAAAA_5555 : 32'h1111_2222, (i % 8) == 7, 1'b0);
      check("toggle_pend", {31'h0, pending}, 32'h0);
      check("toggle_taps", {coef_b16, coef_b17}, 32'h1234_FFFE);
    end
    for (int i = 0; i < 3; i++) tick(32'h1234_FFFE, 1'b0, 1'b0);

    // Pending word, then a new word reaches the sampler together with sync.
    for (int i = 0; i < 7; i++) tick(32'h0BAD_F00D, 1'b0, 1'b0);
    check("race_pend", {31'h0, pending}, 32'h1);
    tick(32'h5A5A_0001, 1'b0, 1'b0);
    tick(32'h5A5A_0001, 1'b1, 1'b0);
    check("race_noapply", {31'h0, coef_update}, 32'h0);
    check("race_taps", {coef_b16, coef_b17}, 32'h1234_FFFE);
    for (int i = 0; i < 3; i++) tick(32'h5A5A_0001, 1'b0, 1'b0);
    check("race_not_yet", {31'h0, pending}, 32'h0);
    tick(32'h5A5A_0001, 1'b0, 1'b0);
    check("race_requal", {31'h0, pending}, 32'h1);
    tick(32'h5A5A_0001, 1'b1, 1'b0);
    check("race_apply", {coef_b16, coef_b17}, 32'h5A5A_0001);

    // Pending word, then a one-cycle reset.
    for (int i = 0; i < 7; i++) tick(32'h8000_7FFF, 1'b0, 1'b0);
    tick(32'h8000_7FFF, 1'b0, 1'b1);
    check("rstmid_taps", {coef_b16, coef_b17}, RST_WORD);
    check("rstmid_pend", {31'h0, pending}, 32'h0);
    for (int i = 0; i < 6; i++) tick(32'h8000_7FFF, 1'b0, 1'b0);
    check("rstmid_requal", {31'h0, pending}, 32'h1);
    tick(32'h8000_7FFF, 1'b1, 1'b0);
    check("rstmid_apply", {coef_b16, coef_b17}, 32'h8000_7FFF);

    // Random traffic from a small word pool.
    for (int k = 0; k < 4; k++) pool[k] = $urandom;
    w = pool[0];
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) w = pool[$urandom_range(3)];
      s = ($urandom_range(3) == 0);
      r = ($urandom_range(299) == 0);
      tick(w, s, r);
    end

    // Counter wrap: CNT_MOD + 1 applies from reset.
    tick(32'h0, 1'b0, 1'b1);
    for (int n = 0; n <= CNT_MOD; n++) begin
      w = {16'(n), ~16'(n)};
      for (int i = 0; i < 7; i++) tick(w, i == 6, 1'b0);
    end
    check("wrap_count", 32'(update_count), 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
